moving_sum: RTL and testbench

Streaming sliding-window sum over the last LENGTH accepted signed samples, used for energy and autocorrelation metrics in packet detection. It sits directly upstream of the saturation stage. It emits a full-precision, bit-growth-exact sum per input sample, which the saturation stage then narrows to the datapath width. It uses valid/ready handshakes on both sides and has a single registered output stage.

---
 rtl/moving_sum.sv | 98 +++++++++
 tb/tb_moving_sum.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/moving_sum.sv
// moving_sum: streaming sliding-window sum over the last LENGTH accepted signed
// samples. Full-precision output (no wrap, no saturation) with valid/ready
// handshakes on both sides and a single registered output stage.
module moving_sum #(
    parameter int WIDTH  = 16,
    parameter int LENGTH = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   clear,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic signed [WIDTH-1:0]                s_data,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic signed [WIDTH+$clog2(LENGTH)-1:0] m_data
);

    localparam int OUT_WIDTH = WIDTH + $clog2(LENGTH);
    localparam int PW        = $clog2(LENGTH);
    localparam int FW        = $clog2(LENGTH + 1);

    // Delay line; contents are never reset because fill masks stale entries.
    logic signed [WIDTH-1:0]     mem_q [LENGTH];

    logic [PW-1:0]               wp_q, wp_d;
    logic [FW-1:0]               fill_q, fill_d;
    logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
    logic signed [OUT_WIDTH-1:0] m_data_q, m_data_d;
    logic                        m_valid_q, m_valid_d;

    logic                        accept;
    logic signed [WIDTH-1:0]     oldest;
    logic signed [OUT_WIDTH-1:0] sum;

    // Handshake decode; clear masks acceptance even when s_ready is high.
    always_comb begin
        s_ready = !m_valid_q || m_ready;
        accept  = s_valid && s_ready && !clear;
    end

    // Window arithmetic: add newest, subtract x[n-LENGTH] once the window is full.
    always_comb begin
        oldest = (fill_q == FW'(LENGTH)) ? mem_q[wp_q] : '0;
        sum    = acc_q + OUT_WIDTH'(s_data) - OUT_WIDTH'(oldest);
    end

    // Next-state logic for pointers, accumulator and output stage.
    always_comb begin
        wp_d      = wp_q;
        fill_d    = fill_q;
        acc_d     = acc_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        if (clear) begin
            wp_d      = '0;
            fill_d    = '0;
            acc_d     = '0;
            m_valid_d = 1'b0;
        end else if (accept) begin
            wp_d      = (wp_q == PW'(LENGTH - 1)) ? '0 : wp_q + 1'b1;
            fill_d    = (fill_q == FW'(LENGTH)) ? fill_q : fill_q + 1'b1;
            acc_d     = sum;
            m_data_d  = sum;
            m_valid_d = 1'b1;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q      <= '0;
            fill_q    <= '0;
            acc_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            fill_q    <= fill_d;
            acc_q     <= acc_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
        end
    end

    // Delay-line write; the read of mem_q[wp_q] above sees the pre-write value.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wp_q] <= s_data;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_moving_sum.sv
// Directed self-checking bench for moving_sum (LENGTH=16 and LENGTH=5 instances).
module tb_moving_sum;

    logic clk;
    logic reset;

    // LENGTH=16 instance
    logic               clear, s_valid, s_ready, m_valid, m_ready;
    logic signed [15:0] s_data;
    logic signed [19:0] m_data;

    // LENGTH=5 instance
    logic               clear5, s_valid5, s_ready5, m_valid5, m_ready5;
    logic signed [15:0] s_data5;
    logic signed [18:0] m_data5;

    int n_checks = 0;
    int n_fail   = 0;

    moving_sum #(.WIDTH(16), .LENGTH(16)) dut16 (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    moving_sum #(.WIDTH(16), .LENGTH(5)) dut5 (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear5),
        .s_valid (s_valid5),
        .s_ready (s_ready5),
        .s_data  (s_data5),
        .m_valid (m_valid5),
        .m_ready (m_ready5),
        .m_data  (m_data5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference window sum of the ramp 1,2,3,... ending at sample n.
    function automatic longint ramp_sum(input int n);
        longint s = 0;
        for (int i = n - 15; i <= n; i++) begin
            if (i >= 1) s += i;
        end
        return s;
    endfunction

    logic [39:0] pat;
    logic        mv;
    longint      md;
    int          kn, jn;
    logic        hs, acc;

    initial begin
        reset = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        clear5 = 1'b0; s_valid5 = 1'b0; s_data5 = '0; m_ready5 = 1'b1;
        #2 reset = 1'b1;
        #10;
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_s_ready", s_ready, 1);
        step();
        reset = 1'b0;
        m_ready = 1'b1;

        // Impulse: 100 then 20 zeros, back-to-back.
        s_valid = 1'b1; s_data = 100;
        step();
        chk("impulse_valid", m_valid, 1);
        chk("impulse_1", m_data, 100);
        for (int i = 2; i <= 21; i++) begin
            s_data = 0;
            step();
            chk($sformatf("impulse_%0d", i), m_data, (i <= 16) ? 100 : 0);
        end
        s_valid = 1'b0;
        step();
        chk("impulse_drain_valid", m_valid, 0);

        // Full-scale negative.
        clear = 1'b1; step(); clear = 1'b0;
        s_valid = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            s_data = -16'sd32768;
            step();
            chk($sformatf("fullneg_%0d", n), m_data, -64'sd32768 * ((n < 16) ? n : 16));
        end
        s_valid = 1'b0;
        step();

        // Ramp under fixed pseudo-random backpressure.
        clear = 1'b1; step(); clear = 1'b0;
        pat = 40'hB5_6C_93_A7_4E;
        mv = 1'b0; md = 0; kn = 1; jn = 1;
        for (int c = 0; c < 40; c++) begin
            m_ready = pat[c];
            s_valid = 1'b1;
            s_data  = 16'(kn);
            #1;
            chk("bp_s_ready", s_ready, (!mv || m_ready) ? 1 : 0);
            hs  = mv && m_ready;
            acc = !mv || m_ready;
            if (hs) begin
                chk($sformatf("bp_consumed_%0d", jn), m_data, ramp_sum(jn));
                jn++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                md = ramp_sum(kn);
                mv = 1'b1;
                kn++;
            end else if (hs) begin
                mv = 1'b0;
            end
            chk("bp_m_valid", m_valid, mv);
            if (mv) chk("bp_m_data", m_data, md);
        end
        s_valid = 1'b0; m_ready = 1'b1;
        step();
        step();

        // Clear concurrent with a valid sample.
        clear = 1'b1; step(); clear = 1'b0;
        s_valid = 1'b1; s_data = 10;
        for (int i = 0; i < 8; i++) step();
        chk("clear_pre_80", m_data, 80);
        clear = 1'b1; s_data = 99;
        step();
        clear = 1'b0;
        chk("clear_m_valid", m_valid, 0);
        chk("clear_s_ready", s_ready, 1);
        s_data = 7;
        step();
        chk("clear_next_7", m_data, 7);
        s_data = 1;
        step();
        chk("clear_next_8", m_data, 8);

        // Async reset between edges with output pending.
        m_ready = 1'b0; s_data = 3;
        step();
        s_valid = 1'b0;
        chk("arst_pre_valid", m_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_m_data", m_data, 0);
        chk("arst_s_ready", s_ready, 1);
        #1 reset = 1'b0;
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = 5;
        step();
        chk("arst_next_5", m_data, 5);
        s_valid = 1'b0;
        step();

        // Non-power-of-two window, LENGTH=5.
        s_valid5 = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            s_data5 = 16'(n);
            step();
            chk($sformatf("len5_%0d", n), m_data5, (n <= 5) ? (n * (n + 1)) / 2 : 5 * n - 10);
        end
        s_valid5 = 1'b0;
        step();
        chk("len5_drain_valid", m_valid5, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
